irq_pending_arbiter: RTL and testbench
======================================

// Module: irq_pending_arbiter
// PURPOSE
//  Captures 8 request lines into sticky pending bits and applies a per-line mask.
//  Presents the highest-priority unmasked pending line (bit 7 highest) as a 3-bit
//  index on a valid/ready handshake. The index is cleared from pending when the
//  consumer accepts it. Sits upstream of the 8:3 priority-encode/dispatch path as
//  its request-buffering stage.
// PARAMETERS
//  EDGE   1   1 = capture rising edges of req; 0 = capture level (req high sets bit)
// PORTS
//  clk        in   1  clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  req        in   8  request lines, synchronous to clk
//  mask       in   8  1 = line masked (stays pending, never presented)
//  irq_ready  in   1  consumer accepts irq_id when irq_valid && irq_ready
//  clr_lost   in   1  clears all lost bits
//  irq_valid  out  1  irq_id is valid
//  irq_id     out  3  index of presented line
//  pending    out  8  registered pending vector
//  lost       out  8  sticky: a new event hit an already-pending bit
// BEHAVIOUR
//  Reset: pending=0, lost=0, irq_valid=0, irq_id=0, req_d=0 (req high at the
//   first post-reset edge counts as a rising edge when EDGE=1).
//  evt = EDGE ? (req & ~req_d) : req; req_d <= req every cycle.
//  acc = irq_valid & irq_ready; clr = acc ? onehot(irq_id) : 0.
//  pending <= (pending & ~clr) | evt. On the same bit, a new event wins over clear.
//  lost[i] <= 1 if evt[i] & pending[i] & ~clr[i]. When clr_lost=1, lost <= 0.
//   clr_lost has priority over a same-cycle set. EDGE=0 with req held: lost
//   sets every cycle the bit is already pending.
//  Output FSM, 2 states, registered outputs:
//   IDLE (irq_valid=0): if |(pending & ~mask), go to PRESENT.
//     irq_id <= index of the highest set bit of (pending & ~mask).
//   PRESENT (irq_valid=1): irq_id held stable regardless of new events/mask changes.
//     On acc, go to IDLE with irq_valid <= 0.
//  Consequences:
//   - One mandatory bubble cycle after every accept.
//   - Max one grant per 2 cycles.
//   - No retraction once valid.
//  Latency: req edge sampled at edge n; pending at n+1; irq_valid at n+2.
//  irq_valid is never 1 when nothing unmasked is pending at decision time.
//   There is no "invalid" output code.
//  rst mid-operation: all state returns to reset values at that edge.
//   Any in-flight grant is dropped.
// TESTING
//  1 EDGE=1, pulse req=8'h04 for 1 cycle, ready=1 -> pending=04 @+1;
//    valid=1,id=2 @+2; pending=00,valid=0 @+3.
//  2 req=8'h81 pulse, ready=1 -> id=7 first; after the bubble, id=0;
//    pending=00 thereafter.
//  3 id=2 valid, ready=0, pulse req bit6 -> id stays 2, pending=44;
//    ready=1 -> next grant id=6.
//  4 mask=8'h80, pulse req=8'h81 -> id=0 granted, pending=80 remains,
//    valid=0; mask=0 -> id=7.
//  5 Pulse bit3 twice before accept -> lost=08, pending=08; clr_lost -> lost=00.
//    Accept id3 in the same cycle as a new bit3 edge -> pending[3]=1, lost[3]=0.
//  6 valid=1 id=5, assert rst 1 cycle -> valid=0, id=0, pending=00, lost=00
//    next edge; EDGE=0 variant: hold req=8'h10 -> repeat grants of id=4.

Source files
------------

// File: rtl/irq_pending_arbiter.sv
// Sticky 8-line interrupt pending register with per-line mask and a registered
// valid/ready presenter of the highest-priority unmasked pending line (bit 7 highest).
module irq_pending_arbiter #(
    parameter int EDGE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       irq_ready,
    input  logic       clr_lost,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic [7:0] pending,
    output logic [7:0] lost
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_req_d;
    logic [7:0] r_pending;
    logic [7:0] r_lost;
    logic [2:0] r_irq_id;
    logic [2:0] w_id_nxt;
    logic [7:0] w_evt;
    logic [7:0] w_clr;
    logic [7:0] w_avail;
    logic       w_acc;

    // Highest set bit wins; the caller guarantees v is non-zero when it matters.
    function automatic logic [2:0] f_highest(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    assign w_evt   = (EDGE != 0) ? (req & ~r_req_d) : req;
    assign w_acc   = (r_state == S_PRESENT) && irq_ready;
    assign w_avail = r_pending & ~mask;

    always_comb begin
        w_clr = '0;
        if (w_acc) w_clr[r_irq_id] = 1'b1;
    end

    // Presented index is frozen while in PRESENT; it is only re-chosen from IDLE,
    // which forces one bubble cycle after each accept.
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_irq_id;
        case (r_state)
            S_IDLE: begin
                if (|w_avail) begin
                    w_state_nxt = S_PRESENT;
                    w_id_nxt    = f_highest(w_avail);
                end
            end
            S_PRESENT: begin
                if (irq_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_req_d   <= '0;
            r_pending <= '0;
            r_lost    <= '0;
            r_irq_id  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_d   <= req;
            r_irq_id  <= w_id_nxt;
            // A new event on a bit being cleared this cycle keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_evt;
            if (clr_lost) r_lost <= '0;
            else          r_lost <= r_lost | (w_evt & r_pending & ~w_clr);
        end
    end

    assign irq_valid = (r_state == S_PRESENT);
    assign irq_id    = r_irq_id;
    assign pending   = r_pending;
    assign lost      = r_lost;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Bench for irq_pending_arbiter: EDGE=1 and EDGE=0 instances on shared stimulus,
// directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_irq_pending_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       irq_ready;
    logic       clr_lost;

    logic       e_valid, l_valid;
    logic [2:0] e_id, l_id;
    logic [7:0] e_pend, l_pend, e_lost, l_lost;

    int n_total;
    int n_bad;
    int grants;

    // Model state, index 0 = EDGE=1 instance, index 1 = EDGE=0 instance
    bit [7:0] m_pend [2];
    bit [7:0] m_lost [2];
    bit [7:0] m_reqd [2];
    bit       m_valid[2];
    int       m_id   [2];

    irq_pending_arbiter #(.EDGE(1)) u_edge (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .irq_ready(irq_ready),
        .clr_lost(clr_lost), .irq_valid(e_valid), .irq_id(e_id),
        .pending(e_pend), .lost(e_lost)
    );

    irq_pending_arbiter #(.EDGE(0)) u_level (
        .clk(clk), .rst(rst), .req(req), .mask(mask), .irq_ready(irq_ready),
        .clr_lost(clr_lost), .irq_valid(l_valid), .irq_id(l_id),
        .pending(l_pend), .lost(l_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of the reference model, using the inputs present at the edge.
    task automatic model_step(input int k);
        bit       use_edge;
        bit [7:0] np, nl;
        bit       ev, cl, accepted, any;
        int       best;
        use_edge = (k == 0);
        if (rst) begin
            m_pend[k] = 0; m_lost[k] = 0; m_reqd[k] = 0; m_valid[k] = 0; m_id[k] = 0;
            return;
        end
        accepted = m_valid[k] && irq_ready;
        np = 0; nl = 0;
        for (int i = 0; i < 8; i++) begin
            ev = use_edge ? (req[i] && !m_reqd[k][i]) : req[i];
            cl = accepted && (m_id[k] == i);
            np[i] = (m_pend[k][i] && !cl) || ev;
            nl[i] = !clr_lost && (m_lost[k][i] || (ev && m_pend[k][i] && !cl));
        end
        if (!m_valid[k]) begin
            any = 0; best = 0;
            for (int i = 7; i >= 0; i--) begin
                if (!any && m_pend[k][i] && !mask[i]) begin
                    any = 1; best = i;
                end
            end
            if (any) begin
                m_valid[k] = 1; m_id[k] = best;
            end
        end else if (accepted) begin
            m_valid[k] = 0;
        end
        m_pend[k] = np;
        m_lost[k] = nl;
        m_reqd[k] = req;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("e_valid", 32'(e_valid), 32'(m_valid[0]));
        chk("e_id",    32'(e_id),    32'(m_id[0]));
        chk("e_pend",  32'(e_pend),  32'(m_pend[0]));
        chk("e_lost",  32'(e_lost),  32'(m_lost[0]));
        chk("l_valid", 32'(l_valid), 32'(m_valid[1]));
        chk("l_id",    32'(l_id),    32'(m_id[1]));
        chk("l_pend",  32'(l_pend),  32'(m_pend[1]));
        chk("l_lost",  32'(l_lost),  32'(m_lost[1]));
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_lost[k] = 0; m_reqd[k] = 0; m_valid[k] = 0; m_id[k] = 0;
        end
        rst = 1; req = 0; mask = 0; irq_ready = 1; clr_lost = 0;
        #2;
        cyc();
        rst = 0;
        chk("rst_valid", 32'(e_valid), 0);
        chk("rst_id",    32'(e_id),    0);
        chk("rst_pend",  32'(e_pend),  0);
        chk("rst_lost",  32'(e_lost),  0);

        // single pulse, latency
        req = 8'h04; cyc();
        chk("t1_pend1", 32'(e_pend), 32'h04);
        chk("t1_val1",  32'(e_valid), 0);
        req = 8'h00; cyc();
        chk("t1_val2",  32'(e_valid), 1);
        chk("t1_id2",   32'(e_id), 2);
        cyc();
        chk("t1_pend3", 32'(e_pend), 0);
        chk("t1_val3",  32'(e_valid), 0);

        // priority with bubble
        req = 8'h81; cyc();
        req = 8'h00; cyc();
        chk("t2_id7", 32'(e_id), 7);
        cyc();
        chk("t2_bubble", 32'(e_valid), 0);
        cyc();
        chk("t2_id0", 32'(e_id), 0);
        chk("t2_val0", 32'(e_valid), 1);
        cyc(); cyc();
        chk("t2_pend", 32'(e_pend), 0);

        // no retraction under backpressure
        irq_ready = 0;
        req = 8'h04; cyc();
        req = 8'h00; cyc();
        req = 8'h40; cyc();
        chk("t3_pend", 32'(e_pend), 32'h44);
        chk("t3_id",   32'(e_id), 2);
        req = 8'h00; cyc();
        irq_ready = 1; cyc();
        cyc();
        chk("t3_id6", 32'(e_id), 6);
        chk("t3_val", 32'(e_valid), 1);
        cyc();

        // mask
        mask = 8'h80;
        req = 8'h81; cyc();
        req = 8'h00; cyc();
        chk("t4_id0", 32'(e_id), 0);
        cyc();
        chk("t4_pend", 32'(e_pend), 32'h80);
        cyc();
        chk("t4_masked", 32'(e_valid), 0);
        mask = 8'h00; cyc();
        chk("t4_id7", 32'(e_id), 7);
        chk("t4_val7", 32'(e_valid), 1);
        cyc();

        // lost bits and accept colliding with a new event
        irq_ready = 0;
        req = 8'h08; cyc();
        req = 8'h00; cyc();
        req = 8'h08; cyc();
        chk("t5_lost", 32'(e_lost), 32'h08);
        chk("t5_pend", 32'(e_pend), 32'h08);
        req = 8'h00; clr_lost = 1; cyc();
        chk("t5_clrlost", 32'(e_lost), 0);
        clr_lost = 0;
        irq_ready = 1; req = 8'h08; cyc();
        chk("t5_keep", 32'(e_pend), 32'h08);
        chk("t5_nolost", 32'(e_lost), 0);
        req = 8'h00; cyc(); cyc(); cyc();

        // reset mid-grant
        irq_ready = 0;
        req = 8'h20; cyc();
        req = 8'h00; cyc();
        chk("t6_id5", 32'(e_id), 5);
        rst = 1; cyc();
        rst = 0;
        chk("t6_valid", 32'(e_valid), 0);
        chk("t6_id",    32'(e_id), 0);
        chk("t6_pend",  32'(e_pend), 0);
        chk("t6_lost",  32'(e_lost), 0);

        // level mode with held request: repeated grants of line 4
        irq_ready = 1; req = 8'h10; grants = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (l_valid && l_id == 3'd4) grants++;
        end
        chk("t6_lvl_grants", 32'(grants), 4);
        req = 8'h00; cyc(); cyc(); cyc();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            req       = 8'($urandom);
            if ($urandom_range(0, 3) == 0) mask = 8'($urandom);
            irq_ready = 1'($urandom_range(0, 1));
            clr_lost  = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
